// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU and response signals of the ALU issue controller
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [5:0]  alu_oprn;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_taken;
  logic        rsp_illegal;
  modport slave (
    input  req_valid, opcode, funct, shamt, imm, rs_data, rt_data, alu_out, alu_zero, rsp_ready,
    output req_ready, alu_op1, alu_op2, alu_oprn, rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_illegal
  );
  modport master (
    output req_valid, opcode, funct, shamt, imm, rs_data, rt_data, alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_op1, alu_op2, alu_oprn, rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one instruction, drives the ALU for a settle window and returns the captured result
module alu_issue_ctrl #(
  parameter int unsigned MUL_SETTLE  = 2,
  parameter int unsigned BASE_SETTLE = 0
) (
  input logic           clk,
  input logic           rst,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [5:0] ADD = 6'h01, SUB = 6'h02, MUL = 6'h03, SHR = 6'h04, SHL = 6'h05;
  localparam logic [5:0] AND = 6'h06, OR = 6'h07, NOR = 6'h08, SLT = 6'h09;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, settle_d;
  logic [31:0] op1_q, op2_q, op1_d, op2_d, res_q;
  logic [5:0]  oprn_q, oprn_d;
  logic [1:0]  br_q, br_d;
  logic        zero_q, taken_q, illegal_q, ill_d, accept, capture;
  assign bus.req_ready   = state_q == IDLE;
  assign bus.rsp_valid   = state_q == RESP;
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.alu_oprn    = oprn_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_taken   = taken_q;
  assign bus.rsp_illegal = illegal_q;
  assign accept  = bus.req_valid && state_q == IDLE;
  assign capture = state_q == EXEC && cnt_q == '0;
  assign ill_d    = oprn_d == '0;
  assign settle_d = oprn_d == MUL ? 8'(MUL_SETTLE) : 8'(BASE_SETTLE);
  // Decode opcode/funct into an ALU code and steered operands; an unmatched encoding leaves the code at 0
  always_comb begin
    op1_d  = bus.rs_data;
    op2_d  = {{16{bus.imm[15]}}, bus.imm};
    oprn_d = '0;
    br_d   = 2'b00;
    if (bus.opcode == 6'h00) begin
      op2_d = bus.rt_data;
      case (bus.funct)
        6'h20: oprn_d = ADD;
        6'h22: oprn_d = SUB;
        6'h2c: oprn_d = MUL;
        6'h24: oprn_d = AND;
        6'h25: oprn_d = OR;
        6'h27: oprn_d = NOR;
        6'h2a: oprn_d = SLT;
        6'h08: begin oprn_d = ADD; op2_d = '0; end
        6'h01: begin oprn_d = SHL; op1_d = bus.rt_data; op2_d = {27'b0, bus.shamt}; end
        6'h02: begin oprn_d = SHR; op1_d = bus.rt_data; op2_d = {27'b0, bus.shamt}; end
        default: ;
      endcase
    end else begin
      case (bus.opcode)
        6'h08, 6'h23, 6'h2b: oprn_d = ADD;
        6'h1d: oprn_d = MUL;
        6'h0a: oprn_d = SLT;
        6'h04: begin oprn_d = SUB; br_d = 2'b01; end
        6'h05: begin oprn_d = SUB; br_d = 2'b10; end
        6'h0c: begin oprn_d = AND; op2_d = {16'b0, bus.imm}; end
        6'h0d: begin oprn_d = OR; op2_d = {16'b0, bus.imm}; end
        6'h0f: begin oprn_d = SHL; op1_d = {16'b0, bus.imm}; op2_d = 32'd16; end
        default: ;
      endcase
    end
    if (ill_d) begin
      op1_d = '0;
      op2_d = '0;
    end
  end
  // Next state: illegal requests skip the ALU and answer immediately
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && bus.req_valid) state_d = ill_d ? RESP : EXEC;
    else if (capture) state_d = RESP;
    else if (state_q == RESP && bus.rsp_ready) state_d = IDLE;
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Operand, settle counter and response registers; ALU inputs change only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      oprn_q    <= '0;
      br_q      <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      oprn_q    <= oprn_d;
      br_q      <= br_d;
      cnt_q     <= settle_d;
      res_q     <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= ill_d;
    end else if (capture) begin
      res_q   <= bus.alu_out;
      zero_q  <= bus.alu_zero;
      taken_q <= br_q == 2'b01 ? bus.alu_zero : br_q == 2'b10 ? !bus.alu_zero : 1'b0;
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end
endmodule
